// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, PC-source and instruction-field definitions
package cpu_pkg;

  localparam logic [5:0] OP_NOOP = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_LUI  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000100;
  localparam logic [5:0] OP_SW   = 6'b000101;
  localparam logic [5:0] OP_SWI  = 6'b000110;
  localparam logic [5:0] OP_LW   = 6'b000111;
  localparam logic [5:0] OP_LWI  = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b100001;
  localparam logic [5:0] OP_BLT  = 6'b100010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int JIDX_MSB = 25;

  // Jump target keeps the current 256 MB region and word-aligns the index.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc_v, input logic [31:0] ir_v);
    return {pc_v[31:28], ir_v[JIDX_MSB:0], 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch take decision from opcode and ALU flags
module branch_cond
  import cpu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       alu_zero_i,
  input  logic       alu_neg_i,
  output logic       take_o
);

  always_comb begin
    take_o = 1'b0;
    case (opcode_i)
      OP_BEQ:  take_o = alu_zero_i;
      OP_BNE:  take_o = ~alu_zero_i;
      OP_BLT:  take_o = alu_neg_i;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_ir_unit.sv
// rtl/fetch_ir_unit.sv - PC/IR holder with stalling fetch; FETCH_PERF_COUNTERS_EN adds counters
module fetch_ir_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            IRWrite,
  input  logic            PCWrite,
  input  logic            PCWriteCond,
  input  logic [1:0]      PCSource,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic [XLEN-1:0] mem_addr,
  output logic            fetch_req,
  output logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ir,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [15:0]     imm16,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]     instr_count,
  output logic [31:0]     branch_taken_count,
  output logic [31:0]     stall_cycles,
`endif
  output logic [XLEN-1:0] jump_target
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic            pend_we_q, pend_we_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic            take;
  logic            pc_we;
  logic            br_we;
  logic [XLEN-1:0] pc_target;
  logic            idle_miss;
  logic            ir_cap;

  branch_cond u_branch_cond (
    .opcode_i   (opcode),
    .alu_zero_i (alu_zero),
    .alu_neg_i  (alu_neg),
    .take_o     (take)
  );

  assign opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign rs          = ir_q[RS_MSB:RS_LSB];
  assign rt          = ir_q[RT_MSB:RT_LSB];
  assign rd          = ir_q[RD_MSB:RD_LSB];
  assign imm16       = ir_q[IMM_MSB:IMM_LSB];
  assign jump_target = jump_addr(pc_q, ir_q);
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign mem_addr    = pc_q;

  always_comb begin
    pc_target = '0;
    case (PCSource)
      PCSRC_ALU:    pc_target = alu_result;
      PCSRC_ALUOUT: pc_target = alu_out;
      PCSRC_JUMP:   pc_target = jump_target;
      default:      pc_target = '0;
    endcase
  end

  // PCSource 11 is reserved and suppresses every PC write.
  assign pc_we = (PCWrite | (PCWriteCond & take)) & (PCSource != 2'b11);
  assign br_we = PCWriteCond & take & ~PCWrite & (PCSource != 2'b11);

  assign idle_miss = (state_q == ST_IDLE) & IRWrite & ~mem_rvalid;
  assign stall     = (state_q == ST_WAIT) | idle_miss;
  assign fetch_req = (state_q == ST_WAIT) | IRWrite;
  assign ir_cap    = mem_rvalid & ((state_q == ST_WAIT) | IRWrite);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pend_we_d = pend_we_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_miss) begin
          state_d   = ST_WAIT;
          pend_we_d = pc_we;
          pend_pc_d = pc_target;
        end else begin
          if (IRWrite) ir_d = mem_rdata;
          if (pc_we) pc_d = pc_target;
        end
      end
      default: begin
        if (mem_rvalid) begin
          state_d   = ST_IDLE;
          ir_d      = mem_rdata;
          pend_we_d = 1'b0;
          if (pend_we_q) pc_d = pend_pc_q;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      pend_we_q <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pend_we_q <= pend_we_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        pend_br_q, pend_br_d;
  logic        br_done;

  // A stalled branch is only counted once its deferred write lands.
  always_comb begin
    pend_br_d = pend_br_q;
    br_done   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (idle_miss) pend_br_d = br_we;
      else           br_done   = br_we;
    end else if (mem_rvalid) begin
      br_done   = pend_br_q;
      pend_br_d = 1'b0;
    end
    instr_count_d = instr_count_q + {31'd0, ir_cap};
    br_count_d    = br_count_q + {31'd0, br_done};
    stall_cnt_d   = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_count_q <= '0;
      br_count_q    <= '0;
      stall_cnt_q   <= '0;
      pend_br_q     <= 1'b0;
    end else begin
      instr_count_q <= instr_count_d;
      br_count_q    <= br_count_d;
      stall_cnt_q   <= stall_cnt_d;
      pend_br_q     <= pend_br_d;
    end
  end

  assign instr_count        = instr_count_q;
  assign branch_taken_count = br_count_q;
  assign stall_cycles       = stall_cnt_q;
`else
  logic unused_cap;
  assign unused_cap = ir_cap | br_we;
`endif

endmodule

// File: tb/tb_fetch_ir_unit.sv
// tb/tb_fetch_ir_unit.sv - scoreboard bench for fetch_ir_unit (FETCH_PERF_COUNTERS_EN optional)
module tb_fetch_ir_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        IRWrite, PCWrite, PCWriteCond;
  logic [1:0]  PCSource;
  logic [31:0] alu_result, alu_out;
  logic        alu_zero, alu_neg;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] mem_addr, pc, ir, jump_target;
  logic        fetch_req, stall;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] instr_count, branch_taken_count, stall_cycles;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  fetch_ir_unit dut (
    .clock       (clock),
    .reset       (reset),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .mem_addr    (mem_addr),
    .fetch_req   (fetch_req),
    .stall       (stall),
    .pc          (pc),
    .ir          (ir),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm16       (imm16),
`ifdef FETCH_PERF_COUNTERS_EN
    .instr_count        (instr_count),
    .branch_taken_count (branch_taken_count),
    .stall_cycles       (stall_cycles),
`endif
    .jump_target (jump_target)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    IRWrite = 0; PCWrite = 0; PCWriteCond = 0; PCSource = 2'b00;
    alu_result = 0; alu_out = 0; alu_zero = 0; alu_neg = 0;
    mem_rdata = 0; mem_rvalid = 0;
  endtask

  task automatic load(input logic [31:0] p, input logic [31:0] w);
    IRWrite = 1; mem_rvalid = 1; mem_rdata = w;
    PCWrite = 1; PCSource = 2'b00; alu_result = p;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick(); tick();
    compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    compared++; if (ir !== 32'h0) begin mismatched++; $display("FAIL reset_ir: got %h expected %h", ir, 32'h0); end
    compared++; if (stall !== 1'b0 || fetch_req !== 1'b0) begin mismatched++; $display("FAIL reset_ctl: got stall=%b fetch_req=%b expected 0/0", stall, fetch_req); end
    reset = 0;
  endtask

  task automatic test_zero_wait();
    IRWrite = 1; PCWrite = 1; PCSource = 2'b00; alu_result = 32'd4;
    mem_rvalid = 1; mem_rdata = 32'h0400_0010;
    sb.push_back('{32'd4, 32'h0400_0010});
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL zw_stall: got %b expected 0", stall); end
    compared++; if (fetch_req !== 1'b1) begin mismatched++; $display("FAIL zw_fetch_req: got %b expected 1", fetch_req); end
    tick();
    idle();
    #1;
    e = sb.pop_front();
    compared++; if (pc !== e.pc || mem_addr !== e.pc) begin mismatched++; $display("FAIL zw_pc: got %h/%h expected %h", pc, mem_addr, e.pc); end
    compared++; if (ir !== e.ir) begin mismatched++; $display("FAIL zw_ir: got %h expected %h", ir, e.ir); end
    compared++; if (opcode !== 6'b000001 || stall !== 1'b0) begin mismatched++; $display("FAIL zw_opcode: got %b stall=%b expected 000001 stall=0", opcode, stall); end
  endtask

  task automatic test_stall_fetch();
    int nst;
    bit done;
    load(32'd8, 32'h0);
    IRWrite = 1; PCWrite = 1; PCSource = 2'b00; alu_result = 32'd12;
    mem_rvalid = 0; mem_rdata = 0;
    sb.push_back('{32'd12, 32'h8000_0000});
    nst = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c == 3) begin mem_rvalid = 1; mem_rdata = 32'h8000_0000; end
      #1;
      if (stall === 1'b1) nst++;
      done = mem_rvalid;
      tick();
      if (c == 0) begin IRWrite = 0; PCWrite = 0; alu_result = 32'h99; end
      if (!done) begin
        compared++; if (pc !== 32'd8) begin mismatched++; $display("FAIL st_pc_hold: cycle %0d got %h expected %h", c, pc, 32'd8); end
      end
    end
    compared++; if (!done) begin mismatched++; $display("FAIL st_timeout: capture never reached"); end
    idle();
    #1;
    e = sb.pop_front();
    compared++; if (pc !== e.pc) begin mismatched++; $display("FAIL st_pc: got %h expected %h", pc, e.pc); end
    compared++; if (ir !== e.ir || opcode !== 6'b100000) begin mismatched++; $display("FAIL st_ir: got %h op %b expected %h op 100000", ir, opcode, e.ir); end
    compared++; if (nst != 4) begin mismatched++; $display("FAIL st_stall_cycles: got %0d expected 4", nst); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL st_stall_release: got %b expected 0", stall); end
  endtask

  task automatic test_cond_branch();
    logic [5:0]  ops [6]  = '{6'b100000, 6'b100001, 6'b100010, 6'b000010, 6'b100001, 6'b100010};
    logic        zs  [6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ns  [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps[6]  = '{32'h40, 32'h10, 32'h40, 32'h10, 32'h40, 32'h10};
    for (int i = 0; i < 6; i++) begin
      load(32'h10, {ops[i], 26'd0});
      PCWriteCond = 1; PCSource = 2'b01; alu_out = 32'h40;
      alu_zero = zs[i]; alu_neg = ns[i];
      sb.push_back('{exps[i], {ops[i], 26'd0}});
      tick();
      idle();
      e = sb.pop_front();
      compared++;
      if (pc !== e.pc || ir !== e.ir) begin
        mismatched++;
        $display("FAIL cond_%0d: got pc=%h ir=%h expected pc=%h ir=%h", i, pc, ir, e.pc, e.ir);
      end
    end
  endtask

  task automatic test_jump();
    load(32'h1000_0000, 32'h0400_0123);
    PCWrite = 1; PCSource = 2'b10;
    #1;
    compared++; if (jump_target !== 32'h1000_048C) begin mismatched++; $display("FAIL jt_comb: got %h expected %h", jump_target, 32'h1000_048C); end
    sb.push_back('{32'h1000_048C, 32'h0400_0123});
    tick();
    idle();
    e = sb.pop_front();
    compared++; if (pc !== e.pc) begin mismatched++; $display("FAIL jump_pc: got %h expected %h", pc, e.pc); end
    load(32'h1000_0000, 32'h0400_0123);
    PCWrite = 1; PCWriteCond = 1; PCSource = 2'b11; alu_result = 32'h55; alu_out = 32'h66;
    sb.push_back('{32'h1000_0000, 32'h0400_0123});
    tick();
    idle();
    e = sb.pop_front();
    compared++; if (pc !== e.pc) begin mismatched++; $display("FAIL reserved_src: got %h expected %h", pc, e.pc); end
  endtask

  task automatic test_reset_in_wait();
    load(32'h20, 32'h0);
    IRWrite = 1; mem_rvalid = 0;
    #1;
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL rw_stall_enter: got %b expected 1", stall); end
    tick();
    IRWrite = 0; PCWrite = 1; PCSource = 2'b00; alu_result = 32'h99;
    tick();
    idle();
    reset = 1;
    tick();
    reset = 0;
    #1;
    compared++; if (pc !== 32'h0 || ir !== 32'h0) begin mismatched++; $display("FAIL rw_reset: got pc=%h ir=%h expected 0/0", pc, ir); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rw_stall: got %b expected 0", stall); end
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    sb.push_back('{32'h0, 32'h0});
    tick(); tick(); tick();
    idle();
    e = sb.pop_front();
    compared++; if (pc !== e.pc || ir !== e.ir) begin mismatched++; $display("FAIL rw_no_apply: got pc=%h ir=%h expected pc=%h ir=%h", pc, ir, e.pc, e.ir); end
  endtask

`ifdef FETCH_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    idle();
    reset = 1;
    tick();
    reset = 0;
    compared++; if (instr_count !== 0 || branch_taken_count !== 0 || stall_cycles !== 0) begin mismatched++; $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0", instr_count, branch_taken_count, stall_cycles); end
    load(32'h10, {6'b100000, 26'd0});
    PCWriteCond = 1; PCSource = 2'b01; alu_out = 32'h40; alu_zero = 1;
    tick();
    idle();
    IRWrite = 1; mem_rvalid = 0;
    tick();
    IRWrite = 0;
    tick();
    mem_rvalid = 1; mem_rdata = {6'b100001, 26'd0};
    tick();
    idle();
    PCWriteCond = 1; PCSource = 2'b01; alu_out = 32'h80; alu_zero = 0;
    tick();
    PCWrite = 1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      IRWrite = 1; mem_rvalid = 1; mem_rdata = 32'h0;
      tick();
    end
    idle();
    compared++; if (instr_count !== 32'd5) begin mismatched++; $display("FAIL perf_instr: got %0d expected 5", instr_count); end
    compared++; if (branch_taken_count !== 32'd2) begin mismatched++; $display("FAIL perf_branch: got %0d expected 2", branch_taken_count); end
    compared++; if (stall_cycles !== 32'd3) begin mismatched++; $display("FAIL perf_stall: got %0d expected 3", stall_cycles); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_zero_wait();
    test_stall_fetch();
    test_cond_branch();
    test_jump();
    test_reset_in_wait();
`ifdef FETCH_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
